// File: rtl/icap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icap_pkg
// Brief    : Shared FSM states, PR status codes and ICAP command constants.
// Revision : 1.0
// ============================================================================
package icap_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_DONE = 2'd2,
        FINISH    = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_PRERR   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    localparam logic [31:0] SYNC_WORD = 32'hAA995566;
    localparam logic [31:0] NOOP      = 32'h20000000;

endpackage
`default_nettype wire

// File: rtl/icap_pr_timer.sv
`default_nettype none
// ============================================================================
// Module   : icap_pr_timer
// Brief    : Loadable saturating up-counter with a terminal-count flag.
// Revision : 1.0
// ============================================================================
module icap_pr_timer #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Compare with >= so a limit of zero still terminates once evaluation starts.
    assign expired = (count >= LIMIT);

endmodule
`default_nettype wire

// File: rtl/icap_pr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icap_pr_ctrl
// Brief    : Streams PR bitstream words into ICAPE3 and reports job status.
//            Define ICAP_PR_CTRL_PERF_EN to add stall/job cycle counters.
// Revision : 1.0
// ============================================================================
module icap_pr_ctrl
    import icap_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] words_written,
    output logic             icap_csib,
    output logic             icap_rdwrb,
    output logic [31:0]      icap_i,
    input  logic             icap_avail,
    input  logic [31:0]      icap_o,
    input  logic             icap_prdone,
    input  logic             icap_prerror,
    output logic [31:0]      icap_status
`ifdef ICAP_PR_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] job_cycles
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       status_nxt;
    logic             accept;
    logic             job_start;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_expired;
    logic             tmr_armed;
    logic [CNT_W-1:0] tmr_count;

    assign s_ready    = (state == WRITE) && icap_avail && !abort;
    assign accept     = s_valid && s_ready;
    assign job_start  = (state == IDLE) && start && !abort;
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign icap_rdwrb = 1'b0;

    assign tmr_load   = accept && s_last;
    assign tmr_en     = (state == WAIT_DONE);
    // PRDONE lags the last write through the wrapper, so skip the first WAIT_DONE cycle.
    assign tmr_armed  = (tmr_count != '0);

    icap_pr_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .load     (tmr_load),
        .load_val ('0),
        .en       (tmr_en),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= IDLE;
            status <= ST_OK;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        case (state)
            IDLE: begin
                if (job_start) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_nxt  = FINISH;
                    status_nxt = ST_ABORT;
                end else if (icap_prerror) begin
                    state_nxt  = FINISH;
                    status_nxt = ST_PRERR;
                end else if (accept && s_last) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (abort) begin
                    state_nxt  = FINISH;
                    status_nxt = ST_ABORT;
                end else if (tmr_armed) begin
                    if (icap_prerror) begin
                        state_nxt  = FINISH;
                        status_nxt = ST_PRERR;
                    end else if (icap_prdone) begin
                        state_nxt  = FINISH;
                        status_nxt = ST_OK;
                    end else if (tmr_expired) begin
                        state_nxt  = FINISH;
                        status_nxt = ST_TIMEOUT;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ICAP write port: one-cycle registered echo of each accepted beat.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            icap_csib <= 1'b1;
            icap_i    <= '0;
        end else begin
            icap_csib <= !accept;
            if (accept) begin
                icap_i <= s_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            words_written <= '0;
        end else if (job_start) begin
            words_written <= '0;
        end else if (accept && (words_written != '1)) begin
            words_written <= words_written + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            icap_status <= '0;
        end else if (icap_csib) begin
            icap_status <= icap_o;
        end
    end

`ifdef ICAP_PR_CTRL_PERF_EN
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            stall_cycles <= '0;
            job_cycles   <= '0;
        end else if (job_start) begin
            stall_cycles <= '0;
            job_cycles   <= '0;
        end else begin
            if ((state == WRITE) && s_valid && !icap_avail && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (((state == WRITE) || (state == WAIT_DONE)) && (job_cycles != '1)) begin
                job_cycles <= job_cycles + CNT_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire
